// File: rtl/bcd_counter_pkg.sv
// Shared types, segment tables and BCD helpers for the six-digit counter.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_t;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_KEYS   = 2;
  localparam int KEY_CLR    = 0;
  localparam int KEY_STEP   = 1;

  typedef bcd_digit_t [NUM_DIGITS-1:0] bcd_count_t;

  typedef struct packed {
    bcd_count_t value;
    logic       wrapped;
  } bcd_step_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam seg_t SEG_DASH = 7'b0111111;

  function automatic seg_t bcd_to_seg(input bcd_digit_t d);
    seg_t s;
    s = SEG_DASH;
    if (d <= 4'd9) s = SEG_DIGIT[d];
    return s;
  endfunction

  // One BCD step with full ripple; wrapped flags 999999->0 or 0->999999.
  function automatic bcd_step_t bcd_step(input bcd_count_t c, input logic up);
    bcd_step_t r;
    logic      carry;
    r     = '0;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r.value[i] = c[i];
      if (carry) begin
        if (up) begin
          if (c[i] >= 4'd9) r.value[i] = 4'd0;
          else begin
            r.value[i] = c[i] + 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (c[i] == 4'd0) r.value[i] = 4'd9;
          else begin
            r.value[i] = c[i] - 4'd1;
            carry      = 1'b0;
          end
        end
      end
    end
    r.wrapped = carry;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low pushbutton -> synchronized, debounced state plus a 1-cycle
// press pulse on the accepted high-to-low transition.
module key_debounce
  import bcd_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          acc_q, acc_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive samples that disagree with the accepted state.
  always_comb begin
    acc_d   = acc_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != acc_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        acc_d   = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      acc_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_ni};
      acc_q   <= acc_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/bcd_counter_hex.sv
// Six-digit BCD up/down counter with prescaler, debounced clear/step keys
// and registered 7-segment outputs.
module bcd_counter_hex
  import bcd_counter_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       en,
  input  logic       up,
  input  logic       clr_key_n,
  input  logic       step_key_n,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       wrap_led
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [NUM_KEYS-1:0]   key_n, press;
  logic [PW-1:0]         presc_q, presc_d;
  bcd_count_t            count_q, count_d;
  logic                  wrap_q, wrap_d;
  seg_t [NUM_DIGITS-1:0] hex_q;
  bcd_step_t             nxt;
  logic                  tick, step_ok;

  assign key_n = {step_key_n, clr_key_n};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i  (CLOCK_50),
      .rst_ni (RESET_N),
      .key_ni (key_n[k]),
      .press_o(press[k])
    );
  end

  assign tick    = en && (presc_q == PW'(DIV - 1));
  assign step_ok = press[KEY_STEP] && !en;
  assign nxt     = bcd_step(count_q, up);

  // Clear beats count; a step landing on a tick still yields a single change.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = wrap_q;
    if (en) presc_d = tick ? '0 : presc_q + 1'b1;
    if (press[KEY_CLR]) begin
      presc_d = '0;
      count_d = '0;
      wrap_d  = 1'b0;
    end else if (tick || step_ok) begin
      count_d = nxt.value;
      if (nxt.wrapped) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_DIGIT[0];
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= bcd_to_seg(count_q[i]);
    end
  end

  assign HEX0     = hex_q[0];
  assign HEX1     = hex_q[1];
  assign HEX2     = hex_q[2];
  assign HEX3     = hex_q[3];
  assign HEX4     = hex_q[4];
  assign HEX5     = hex_q[5];
  assign wrap_led = wrap_q;

endmodule

// File: tb/tb_bcd_counter_hex.sv
// Directed bench for bcd_counter_hex with DIV=10 and 4-sample debounce.
module tb_bcd_counter_hex;

  logic       clk, rst_n, en, up, clr_n, step_n;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       wrap_led;
  int         total, bad;

  localparam logic [6:0] SEGS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    int         k;
    int         disp;
    logic [6:0] hex0;
    logic       wrap;
  } vec_t;
  vec_t vecs [9];

  bcd_counter_hex #(.CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .en(en), .up(up),
    .clr_key_n(clr_n), .step_key_n(step_n),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .wrap_led(wrap_led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] get_hex(input int i);
    case (i)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      4: return HEX4;
      default: return HEX5;
    endcase
  endfunction

  function automatic int seg2dig(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (s === SEGS[d]) return d;
    return -1;
  endfunction

  function automatic int disp_val();
    int v;
    int d;
    v = 0;
    for (int i = 5; i >= 0; i--) begin
      d = seg2dig(get_hex(i));
      if (d < 0) return -1;
      v = v * 10 + d;
    end
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_disp(input int want, input int budget, input string name);
    int n;
    n = 0;
    while (disp_val() != want && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, disp_val(), want);
  endtask

  task automatic press_key(input bit is_clr, input int hold);
    if (is_clr) clr_n = 1'b0;
    else step_n = 1'b0;
    cyc(hold);
    clr_n  = 1'b1;
    step_n = 1'b1;
    cyc(8);
  endtask

  initial begin
    int cur;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    up     = 1'b1;
    clr_n  = 1'b1;
    step_n = 1'b1;

    // k = negedges after reset release; display lags count by one cycle
    vecs[0] = '{1,   0,  7'b1000000, 1'b0};
    vecs[1] = '{10,  0,  7'b1000000, 1'b0};
    vecs[2] = '{11,  1,  7'b1111001, 1'b0};
    vecs[3] = '{20,  1,  7'b1111001, 1'b0};
    vecs[4] = '{21,  2,  7'b0100100, 1'b0};
    vecs[5] = '{31,  3,  7'b0110000, 1'b0};
    vecs[6] = '{55,  5,  7'b0010010, 1'b0};
    vecs[7] = '{101, 10, 7'b1000000, 1'b0};
    vecs[8] = '{105, 10, 7'b1000000, 1'b0};

    cyc(3);
    for (int i = 0; i < 6; i++) chk($sformatf("reset_hex%0d", i), get_hex(i), 7'b1000000);
    chk("reset_wrap", wrap_led, 0);

    rst_n = 1'b1;
    cur   = 0;
    foreach (vecs[i]) begin
      cyc(vecs[i].k - cur);
      cur = vecs[i].k;
      chk($sformatf("run_disp_k%0d", vecs[i].k), disp_val(), vecs[i].disp);
      chk($sformatf("run_hex0_k%0d", vecs[i].k), HEX0, vecs[i].hex0);
      chk($sformatf("run_wrap_k%0d", vecs[i].k), wrap_led, vecs[i].wrap);
    end

    en = 1'b0;
    press_key(1'b1, 8);
    chk("clr1_disp", disp_val(), 0);
    chk("clr1_wrap", wrap_led, 0);

    // Clean step down from 000000: count changes 7 edges after the raw fall
    up     = 1'b0;
    step_n = 1'b0;
    cyc(6);
    chk("step_wrap_e6", wrap_led, 0);
    cyc(1);
    chk("step_wrap_e7", wrap_led, 1);
    chk("step_disp_e7", disp_val(), 0);
    cyc(1);
    chk("step_disp_e8", disp_val(), 999999);
    step_n = 1'b1;
    cyc(10);
    chk("step_release", disp_val(), 999999);

    press_key(1'b0, 8);
    chk("step2_disp", disp_val(), 999998);

    // Bouncing key: 2-cycle runs never satisfy 4 stable samples
    for (int i = 0; i < 10; i++) begin
      step_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(2);
    end
    step_n = 1'b0;
    cyc(12);
    chk("bounce_once", disp_val(), 999997);
    step_n = 1'b1;
    cyc(12);
    chk("bounce_release", disp_val(), 999997);

    en = 1'b1;
    up = 1'b1;
    wait_disp(999999, 40, "up_to_top");
    wait_disp(0, 20, "up_wrap_disp");
    en = 1'b0;
    chk("up_wrap_led", wrap_led, 1);
    press_key(1'b1, 8);
    chk("clr2_disp", disp_val(), 0);
    chk("clr2_wrap", wrap_led, 0);

    // Clear pulse lands on the tick edge that would make 123 -> 124
    en = 1'b1;
    cyc(1233);
    clr_n = 1'b0;
    cyc(7);
    chk("clrtick_pre", disp_val(), 123);
    cyc(1);
    chk("clrtick_clr", disp_val(), 0);
    cyc(9);
    chk("clrtick_hold", disp_val(), 0);
    cyc(1);
    chk("clrtick_next", disp_val(), 1);
    clr_n = 1'b1;

    wait_disp(4567, 50000, "reach_4567");
    cyc(3);
    step_n = 1'b0;
    en     = 1'b0;
    up     = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) chk($sformatf("async_hex%0d", i), get_hex(i), 7'b1000000);
    chk("async_wrap", wrap_led, 0);
    cyc(3);
    chk("inreset_disp", disp_val(), 0);
    rst_n = 1'b1;
    cyc(7);
    chk("held_e7", disp_val(), 0);
    cyc(1);
    chk("held_e8", disp_val(), 1);
    cyc(20);
    chk("held_once", disp_val(), 1);
    step_n = 1'b1;
    cyc(10);
    chk("held_release", disp_val(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_hex.md
# bcd_counter_hex

Six-digit decimal up/down counter for the DE1-SoC counter lab. It sits directly under the board top level, consumes CLOCK_50, SW and KEY, and drives HEX5..HEX0 and LEDR[0]. A prescaler produces the count rate, two debounced pushbuttons provide clear and single-step, and a registered 7-segment decoder presents the count.

## Interface
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 10, count rate when enabled. DIV = CLK_HZ/TICK_HZ; DIV must be at least 2.
- DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable synchronized samples required before a key state is accepted (20 ms at 50 MHz).
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- en  in  1  free-run enable (SW[0]); synchronous to CLOCK_50.
- up  in  1  direction (SW[1]): 1 = up, 0 = down.
- clr_key_n  in  1  raw KEY[1], active-low, asynchronous, bouncy.
- step_key_n  in  1  raw KEY[2], active-low, asynchronous, bouncy.
- HEX0..HEX5  out  7 each  active-low segments {g,f,e,d,c,b,a}. HEX0 is the least-significant digit.
- wrap_led  out  1  sticky wrap indicator (LEDR[0]).

## Operation
- Reset values:
  - count = 000000, prescaler = 0, debouncers report "released", wrap_led = 0.
  - HEX0..HEX5 = 7'b1000000 (the digit "0").
- Prescaler: counts 0..DIV-1 and wraps. tick = (prescaler == DIV-1) && en. When en = 0 the prescaler holds its value.
- Debounce:
  - Each key passes through a 2-FF synchronizer and a stability counter.
  - The accepted state changes only after DEBOUNCE_CYCLES identical synchronized samples.
  - A press event is a 1-cycle pulse on the accepted high→low transition. A release generates no event.
- step event: increments or decrements the count by one, only when en = 0. Ignored when en = 1.
- Count update priority, one action per cycle:
  1. clear event: count = 0, prescaler = 0, wrap_led = 0.
  2. tick or step: ±1. A step coinciding with a tick yields one change, not two.
  3. Otherwise hold.
- BCD arithmetic:
  - Each digit is 4 bits, range 0..9. A carry or borrow ripples across all six digits within one cycle.
  - Up: 999999 → 000000. Down: 000000 → 999999.
  - Either wrap sets wrap_led, which stays set until a clear event or reset.
- Decoder: digit 0..9 uses the standard active-low pattern. Digit codes 10..15 are unreachable; if they occur, the decoder outputs 7'b0111111 ("-").
- A direction change takes effect on the next tick or step. No count glitch is allowed.
- An asserted RESET_N mid-count returns everything immediately to the reset values. The debouncers restart from "released", so a key held through reset produces one press event after DEBOUNCE_CYCLES.

## Timing
- Free-run: the first increment occurs at the DIVth rising edge after reset release with en = 1. Increments then repeat every DIV cycles.
- Key latency:
  - The press pulse asserts DEBOUNCE_CYCLES+2 cycles after the raw key is first sampled low and stays stable.
  - The count changes on the edge that samples the pulse.
- HEX outputs are registered: the display reflects count one cycle after count changes. No combinational path from inputs to outputs.
- wrap_led sets on the same edge the count wraps.

## Structure
- Shared package bcd_counter_pkg:
  - type bcd_digit_t (4 bits) and type seg_t (7 bits).
  - constant SEG_DIGIT[0:9] and constant SEG_DASH.
  - function bcd_to_seg.
- Sub-module key_debounce: instantiated twice. Contains the synchronizer, stability counter, accepted state and press pulse. Parameter DEBOUNCE_CYCLES.
- Prescaler, BCD counter and output registers live in bcd_counter_hex itself.

## Test plan
All tests use CLK_HZ=100, TICK_HZ=10 (DIV=10) and DEBOUNCE_CYCLES=4.
- Reset then en=1, up=1 for 105 cycles → count advances every 10 cycles, reaching 000010. The HEX0 pattern sequence is 1000000, 1111001, 0100100, ... with a 1-cycle lag behind count.
- Preload near the top by stepping, count up from 999998 → 999999, then 000000 with wrap_led=1. Then a clr press → 000000 and wrap_led=0.
- en=0, up=0, count 000000, one clean step press → 999999 and wrap_led=1, 7 cycles after the raw fall.
- Bouncy step key (toggling every 2 cycles for 20 cycles, then held low) → exactly one decrement. Release → no change.
- clr event on the same cycle as a tick with count 000123 → count 000000 and prescaler 0. The next increment follows 10 cycles later.
- RESET_N asserted asynchronously mid-tick with count 004567 → on the same cycle all HEX = 1000000 and wrap_led = 0. Key held low through reset → one press event after release.
